// File: rtl/ddr_rd_return_buf_if.sv
// ddr_rd_return_buf_if: signal bundle for the read request / dispatch / return buffer.
// Ports summary (slave = buffer side):
//    request  : read_address, read_req in; read_allowed, reads_pending, outstanding out
//    dispatch : f2a_app_adx, f2a_has_rd_req out; f2a_get_rd_adr in
//    app data : app_rd_data_valid, app_rd_data in
//    return   : return_data, return_adx, return_data_available, orphan_beat out; get_return_data in
interface ddr_rd_return_buf_if #(
   parameter int ADDR_W = 27,
   parameter int BEAT_W = 64,
   parameter int BEATS  = 2,
   parameter int DEPTH  = 64
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [ADDR_W-1:0]       read_address;
   logic                    read_req;
   logic                    read_allowed;
   logic                    reads_pending;
   logic [CW-1:0]           outstanding;
   logic [ADDR_W-1:0]       f2a_app_adx;
   logic                    f2a_has_rd_req;
   logic                    f2a_get_rd_adr;
   logic                    app_rd_data_valid;
   logic [BEAT_W-1:0]       app_rd_data;
   logic [BEATS*BEAT_W-1:0] return_data;
   logic [ADDR_W-1:0]       return_adx;
   logic                    return_data_available;
   logic                    get_return_data;
   logic                    orphan_beat;
   modport slave (
      input  read_address, read_req, f2a_get_rd_adr, app_rd_data_valid, app_rd_data, get_return_data,
      output read_allowed, reads_pending, outstanding, f2a_app_adx, f2a_has_rd_req,
             return_data, return_adx, return_data_available, orphan_beat
   );
   modport master (
      output read_address, read_req, f2a_get_rd_adr, app_rd_data_valid, app_rd_data, get_return_data,
      input  read_allowed, reads_pending, outstanding, f2a_app_adx, f2a_has_rd_req,
             return_data, return_adx, return_data_available, orphan_beat
   );
endinterface

// File: rtl/ddr_rd_return_buf.sv
// ddr_rd_return_buf: credit-limited read address queueing and multi-beat read return assembly.
// Ports:
//    clk   : clock, all logic on posedge
//    reset : synchronous active-high reset
//    bus   : ddr_rd_return_buf_if.slave (request, dispatch, app read data and return channels)
// Internal FWFT FIFO: head visible combinationally, push/pop legal together at any fill level.
module ddr_rd_return_buf_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [W-1:0]           din_i,
   input  logic                   pop_i,
   output logic [W-1:0]           dout_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          pop;
   // a pop on an empty FIFO is ignored
   assign pop     = pop_i & (cnt_q != '0);
   assign dout_o  = mem_q[rptr_q];
   assign count_o = cnt_q;
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= din_i;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_q + AW'(push_i);
         rptr_q <= rptr_q + AW'(pop);
         cnt_q  <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop);
      end
   end
endmodule

module ddr_rd_return_buf #(
   parameter int ADDR_W = 27,
   parameter int BEAT_W = 64,
   parameter int BEATS  = 2,
   parameter int DEPTH  = 64
) (
   input logic                clk,
   input logic                reset,
   ddr_rd_return_buf_if.slave bus
);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int RW  = BEATS * BEAT_W;
   localparam int BCW = BEATS > 1 ? $clog2(BEATS) : 1;
   typedef enum logic {IDLE, FILL} state_t;
   state_t               state_q, state_d;
   logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
   logic [RW-1:0]        beats_q, beats_d, ret_word;
   logic                 orphan_q, orphan_d;
   logic                 acc, last, store, commit, orphan_set;
   logic [CW-1:0]        disp_cnt, pend_cnt, ret_cnt;
   logic [ADDR_W-1:0]    pend_head;
   logic [ADDR_W+RW-1:0] ret_head;
   // pending + returned entries never exceed DEPTH, so the return FIFO cannot overflow
   assign bus.outstanding           = pend_cnt + ret_cnt;
   assign bus.read_allowed          = bus.outstanding < CW'(DEPTH);
   assign bus.reads_pending         = pend_cnt != '0;
   assign bus.f2a_has_rd_req        = disp_cnt != '0;
   assign bus.return_data_available = ret_cnt != '0;
   assign {bus.return_adx, bus.return_data} = ret_head;
   assign bus.orphan_beat           = orphan_q;
   assign acc = bus.read_req & bus.read_allowed;
   ddr_rd_return_buf_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_disp (
      .clk(clk), .reset(reset), .push_i(acc), .din_i(bus.read_address),
      .pop_i(bus.f2a_get_rd_adr), .dout_o(bus.f2a_app_adx), .count_o(disp_cnt)
   );
   ddr_rd_return_buf_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pend (
      .clk(clk), .reset(reset), .push_i(acc), .din_i(bus.read_address),
      .pop_i(commit), .dout_o(pend_head), .count_o(pend_cnt)
   );
   ddr_rd_return_buf_fifo #(.W(ADDR_W+RW), .DEPTH(DEPTH)) u_ret (
      .clk(clk), .reset(reset), .push_i(commit), .din_i({pend_head, ret_word}),
      .pop_i(bus.get_return_data), .dout_o(ret_head), .count_o(ret_cnt)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         beats_q    <= '0;
         orphan_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         beats_q    <= beats_d;
         orphan_q   <= orphan_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      beats_d    = beats_q;
      orphan_d   = orphan_q | orphan_set;
      if (store) begin
         beats_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = bus.app_rd_data;
         beat_cnt_d = last ? '0 : beat_cnt_q + BCW'(1);
         state_d    = last ? IDLE : FILL;
      end
   end
   // the last beat bypasses storage so the word commits in the beat's own cycle
   always_comb begin
      last       = (state_q == FILL) ? (beat_cnt_q == BCW'(BEATS-1)) : (BEATS == 1);
      store      = bus.app_rd_data_valid & ((state_q == FILL) | (pend_cnt != '0));
      commit     = store & last;
      orphan_set = bus.app_rd_data_valid & (state_q == IDLE) & (pend_cnt == '0);
      ret_word   = beats_q;
      ret_word[(BEATS-1)*BEAT_W +: BEAT_W] = bus.app_rd_data;
   end
endmodule
